// File: rtl/ks_add_arbiter_pkg.sv
// Shared definitions for the Kogge-Stone add arbiter: FSM encoding, operand width
// and the saturation value used when KS_ARB_SAT_EN is defined.
package ks_add_arbiter_pkg;

  localparam int OPW = 16;
  localparam logic [OPW-1:0] SAT_VAL = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Unsigned saturation: any carry-out pins the result at the maximum value.
  function automatic logic [OPW-1:0] sat_sum(input logic [OPW-1:0] sum, input logic carry);
    return carry ? SAT_VAL : sum;
  endfunction

endpackage

// File: rtl/KS_top.sv
// 16-bit Kogge-Stone parallel-prefix adder (no carry-in), shared by the arbiter.
module KS_top
  import ks_add_arbiter_pkg::*;
(
  input  logic [OPW-1:0] a_i,
  input  logic [OPW-1:0] b_i,
  output logic [OPW-1:0] sum_o,
  output logic           cout_o
);

  logic [OPW-1:0] p0_s;
  logic [OPW-1:0] gpre_s;

  assign p0_s = a_i ^ b_i;

  // Four prefix levels (span 1,2,4,8); after them gpre_s[i] is the carry out of bit i.
  always_comb begin
    logic [OPW-1:0] g_v;
    logic [OPW-1:0] p_v;
    g_v = a_i & b_i;
    p_v = p0_s;
    for (int l = 0; l < 4; l++) begin
      g_v = g_v | (p_v & (g_v << (1 << l)));
      p_v = p_v & (p_v << (1 << l));
    end
    gpre_s = g_v;
  end

  assign sum_o  = p0_s ^ {gpre_s[OPW-2:0], 1'b0};
  assign cout_o = gpre_s[OPW-1];

endmodule

// File: rtl/ks_rr_arbiter.sv
// Grant selector: round-robin search from ptr_i, or fixed priority (index 0 first)
// when mode_i is set. Output is one-hot, or zero when nothing is valid.
module ks_rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [1:0]      ptr_i,
  input  logic            mode_i,
  output logic [NREQ-1:0] grant_o
);

  // Walk the requesters in search order and grant the first valid one.
  always_comb begin
    logic found_v;
    int   idx_v;
    grant_o = '0;
    found_v = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      idx_v = (mode_i ? 0 : int'(ptr_i)) + off;
      if (idx_v >= NREQ) begin
        idx_v = idx_v - NREQ;
      end else begin
        idx_v = idx_v;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!found_v && (i == idx_v) && valid_i[i]) begin
          grant_o[i] = 1'b1;
          found_v    = 1'b1;
        end else begin
          found_v = found_v;
        end
      end
    end
  end

endmodule

// File: rtl/ks_add_arbiter.sv
// Arbitrates NREQ operand pairs onto one shared Kogge-Stone adder (IDLE/ADD/RESP).
// Optional macro KS_ARB_SAT_EN saturates rsp_sum to 16'hFFFF on carry-out.
module ks_add_arbiter
  import ks_add_arbiter_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int PRIO_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*OPW-1:0] req_a,
  input  logic [NREQ*OPW-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [OPW-1:0]      rsp_sum,
  output logic                rsp_carry,
  output logic [1:0]          rsp_src
);

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [OPW-1:0]  op_a_q, op_b_q;
  logic [1:0]      src_q;
  logic            rsp_valid_q;
  logic [OPW-1:0]  rsp_sum_q;
  logic            rsp_carry_q;
  logic [1:0]      rsp_src_q;

  logic [NREQ-1:0] grant_s;
  logic [1:0]      grant_idx_s;
  logic [OPW-1:0]  sel_a_s, sel_b_s;
  logic            accept_s;
  logic            mode_s;
  logic [OPW-1:0]  ks_sum_s;
  logic            ks_cout_s;
  logic [OPW-1:0]  sum_res_s;

  assign mode_s = (PRIO_MODE == 1);

  ks_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .mode_i  (mode_s),
    .grant_o (grant_s)
  );

  KS_top u_add (
    .a_i    (op_a_q),
    .b_i    (op_b_q),
    .sum_o  (ks_sum_s),
    .cout_o (ks_cout_s)
  );

  // Encode the one-hot grant and mux the winner's operands.
  always_comb begin
    grant_idx_s = 2'd0;
    sel_a_s     = '0;
    sel_b_s     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s[i]) begin
        grant_idx_s = 2'(i);
        sel_a_s     = req_a[i*OPW +: OPW];
        sel_b_s     = req_b[i*OPW +: OPW];
      end else begin
        grant_idx_s = grant_idx_s;
      end
    end
  end

  // Next-state and accept decision; a new request is taken in IDLE or while a result drains.
  always_comb begin
    state_d  = state_q;
    accept_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          accept_s = 1'b1;
          state_d  = ST_ADD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADD: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          accept_s = |req_valid;
          state_d  = (|req_valid) ? ST_ADD : ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pointer advances past the granted requester; wraps at NREQ.
  always_comb begin
    if (accept_s) begin
      if (int'(grant_idx_s) == NREQ - 1) begin
        ptr_d = 2'd0;
      end else begin
        ptr_d = grant_idx_s + 2'd1;
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

`ifdef KS_ARB_SAT_EN
  assign sum_res_s = sat_sum(ks_sum_s, ks_cout_s);
`else
  assign sum_res_s = ks_sum_s;
`endif

  assign req_ready = (accept_s && !rst) ? grant_s : '0;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand latch, pointer and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= 2'd0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      src_q       <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      rsp_src_q   <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
      if (accept_s) begin
        op_a_q <= sel_a_s;
        op_b_q <= sel_b_s;
        src_q  <= grant_idx_s;
      end
      if (state_q == ST_ADD) begin
        rsp_valid_q <= 1'b1;
        rsp_sum_q   <= sum_res_s;
        rsp_carry_q <= ks_cout_s;
        rsp_src_q   <= src_q;
      end else if ((state_q == ST_RESP) && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_src   = rsp_src_q;

endmodule

// File: doc/ks_add_arbiter.md
KS_ADD_ARBITER -- requirements
Module: ks_add_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters (legal 2..4).
REQ-002 SHALL have parameter PRIO_MODE, default 0, 0 = round-robin, 1 = fixed priority (index 0 highest).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, NREQ, per-requester operand valid.
REQ-006 SHALL have port req_ready, output, NREQ, per-requester grant/accept, one-hot or zero.
REQ-007 SHALL have port req_a, input, NREQ*16, packed operand A; requester i at [16i+15:16i].
REQ-008 SHALL have port req_b, input, NREQ*16, packed operand B, same packing.
REQ-009 SHALL have port rsp_valid, output, 1, result valid.
REQ-010 SHALL have port rsp_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port rsp_sum, output, 16, registered sum.
REQ-012 SHALL have port rsp_carry, output, 1, registered carry-out.
REQ-013 SHALL have port rsp_src, output, 2, index of requester that produced the result.

Function
REQ-014 SHALL share one instance of the team's 16-bit Kogge-Stone adder (KS_top) among all requesters; no other adder.
REQ-015 SHALL implement FSM states IDLE, ADD, RESP.
REQ-016 IDLE: any req_valid -> assert req_ready for the winner only, latch its A/B and index, go to ADD; else stay.
REQ-017 ADD: adder evaluates latched operands; sum, carry and src registered into rsp_*; rsp_valid=1 next cycle; go to RESP.
REQ-018 RESP: hold rsp_* stable while rsp_valid=1 and rsp_ready=0.
REQ-019 RESP with rsp_ready=1: if any req_valid, accept new winner same cycle and go to ADD, else go to IDLE; rsp_valid drops next cycle unless re-filled.
REQ-020 Latency accept->rsp_valid SHALL be exactly 2 cycles; sustained throughput one result per 2 cycles.
REQ-021 req_ready SHALL be 0 in ADD and in RESP with rsp_ready=0.
REQ-022 Round-robin: search starts at pointer; after a grant pointer = (granted+1) mod NREQ; pointer unchanged when no grant.
REQ-023 Fixed priority: lowest asserted index wins; pointer unused.
REQ-024 Operands SHALL be consumed only on req_valid&req_ready; a requester dropping req_valid before grant is never served.
REQ-025 Sum arithmetic SHALL be modulo 2^16, carry = bit 16 of A+B.

Reset
REQ-026 rst SHALL, at the next clk edge, force: state IDLE, pointer 0, rsp_valid 0, rsp_sum 0, rsp_carry 0, rsp_src 0, latched operands 0.
REQ-027 req_ready SHALL be 0 while rst=1.
REQ-028 rst mid-operation (ADD or RESP) SHALL discard the in-flight result; no rsp_valid pulse for it.

Configuration
REQ-029 Macro KS_ARB_SAT_EN defined: when carry=1, rsp_sum SHALL be 16'hFFFF (unsigned saturation); rsp_carry still reports raw carry.
REQ-030 Macro KS_ARB_SAT_EN undefined: rsp_sum SHALL be the raw modulo sum; no saturation logic present.

Structure
REQ-031 Shared package SHALL hold the FSM state encoding (IDLE/ADD/RESP), the operand width constant 16 and the saturation constant 16'hFFFF.
REQ-032 Arbitration SHALL be a separate sub-module ks_rr_arbiter (inputs valid vector, pointer, mode; output one-hot grant).

Verification
REQ-033 Single op: req0 A=16'h1234 B=16'h0001 -> 2 cycles later rsp_sum=16'h1235, carry=0, src=0.
REQ-034 Overflow: A=16'hFFFF B=16'h0002 -> sum=16'h0001 carry=1; with KS_ARB_SAT_EN sum=16'hFFFF carry=1.
REQ-035 Round-robin, NREQ=2, both valid continuously, rsp_ready=1 -> src sequence 0,1,0,1; one result every 2 cycles.
REQ-036 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=0 throughout; result consumed on first rsp_ready=1.
REQ-037 Fixed priority PRIO_MODE=1, req0 and req1 always valid -> src always 0; req1 never granted.
REQ-038 Reset in ADD -> next cycle rsp_valid=0, state IDLE, pointer 0; following request produces correct result.
